btb_update_engine: RTL and testbench

Two-way set-associative branch target buffer with bimodal counters, owning both the fetch-side lookup port and the execute-side training port. It consumes the branch unit's registered resolution bundle (vpc, target, counter snapshot, taken, type, present, way, bm-modify, exception) and produces the per-fetch prediction fields (valid, target, type, counter, way) that the branch unit later checks. It sits between fetch and the branch unit, closing the predictor training loop.

---
 rtl/btb_pkg.sv | 33 +++
 rtl/btb_set_ram.sv | 39 +++
 rtl/btb_update_engine.sv | 205 ++++++++++++++++++++
 tb/tb_btb_update_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer: branch encodings, entry layout,
// FSM states and saturating bimodal counter helpers.
package btb_pkg;

  typedef enum logic [1:0] {
    BT_COND = 2'b00,
    BT_CALL = 2'b01,
    BT_JUMP = 2'b10,
    BT_RET  = 2'b11
  } btype_e;

  localparam logic [1:0] CTR_INIT = 2'b10;

  // Tag holds pc >> IDX, zero-extended so the struct is independent of SETS.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] target;
    logic [1:0]  btype;
    logic [1:0]  ctr;
  } btb_entry_t;

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_set_ram.sv
// SETS x 2 entry array with per-set LRU bit: two async read ports
// (lookup, training) and one masked write port.
module btb_set_ram
  import btb_pkg::*;
#(
  parameter int SETS = 64,
  parameter int IDX  = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic [IDX-1:0]        lk_idx,
  output btb_entry_t [1:0]      lk_set,
  input  logic [IDX-1:0]        tr_idx,
  output btb_entry_t [1:0]      tr_set,
  output logic                  tr_lru,
  input  logic                  we,
  input  logic [IDX-1:0]        wr_idx,
  input  logic [1:0]            wr_mask,
  input  btb_entry_t            wr_entry,
  input  logic                  lru_we,
  input  logic                  wr_lru
);

  btb_entry_t [1:0] mem [SETS];
  logic [SETS-1:0]  lru;

  assign lk_set = mem[lk_idx];
  assign tr_set = mem[tr_idx];
  assign tr_lru = lru[tr_idx];

  // No reset: the init sweep clears valid and LRU of every set.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int w = 0; w < 2; w++)
        if (wr_mask[w]) mem[wr_idx][w] <= wr_entry;
      if (lru_we) lru[wr_idx] <= wr_lru;
    end
  end

endmodule

// File: rtl/btb_update_engine.sv
// Two-way BTB with bimodal counters: registered fetch lookup port plus a
// two-stage (read/decide, write) training pipeline with T1->T0 forwarding.
module btb_update_engine
  import btb_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        lookup_valid_i,
  input  logic [29:0] lookup_pc_i,
  output logic        btb_vld_o,
  output logic [29:0] btb_target_o,
  output logic [1:0]  btype_o,
  output logic [1:0]  bm_pred_o,
  output logic        btb_way_o,
  output logic        ready_o,
  input  logic [29:0] c1_btb_vpc_i,
  input  logic [31:0] c1_btb_target_i,
  input  logic [1:0]  c1_cntr_pred_i,
  input  logic        c1_bnch_tkn_i,
  input  logic        c1_bnch_present_i,
  input  logic [1:0]  c1_bnch_type_i,
  input  logic        c1_btb_way_i,
  input  logic        c1_btb_bm_mod_i,
  input  logic        rcu_excp_i
);

  localparam int IDX = $clog2(SETS);

  state_e           state_q, state_d;
  logic [IDX-1:0]   idx_q, idx_d;
  logic             sweep;

  btb_entry_t [1:0] lk_set, tr_set, fset;
  logic             tr_lru, flru;

  logic             t1_we, t1_lru_we, t1_lru;
  logic [IDX-1:0]   t1_idx;
  logic [1:0]       t1_mask;
  btb_entry_t       t1_entry;

  logic             d_we, d_lru_we, d_lru;
  logic [1:0]       d_mask;
  btb_entry_t       d_entry;

  logic             we, lru_we, wr_lru;
  logic [IDX-1:0]   wr_idx;
  logic [1:0]       wr_mask;
  btb_entry_t       wr_entry;

  // Way and counter snapshot from fetch are informational only.
  logic unused_info;
  assign unused_info = ^{c1_cntr_pred_i, c1_btb_way_i, c1_btb_target_i[1:0]};

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sweep   = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX'(SETS - 1)) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  btb_set_ram #(.SETS(SETS), .IDX(IDX)) u_ram (
    .clk      (cpu_clock_i),
    .lk_idx   (lookup_pc_i[IDX-1:0]),
    .lk_set   (lk_set),
    .tr_idx   (c1_btb_vpc_i[IDX-1:0]),
    .tr_set   (tr_set),
    .tr_lru   (tr_lru),
    .we       (we),
    .wr_idx   (wr_idx),
    .wr_mask  (wr_mask),
    .wr_entry (wr_entry),
    .lru_we   (lru_we),
    .wr_lru   (wr_lru)
  );

  // Lookup: way 0 wins on a double match.
  logic [29:0] lk_tag;
  logic        lk_hit0, lk_hit1, lk_way;
  assign lk_tag  = lookup_pc_i >> IDX;
  assign lk_hit0 = lk_set[0].valid && (lk_set[0].tag == lk_tag);
  assign lk_hit1 = lk_set[1].valid && (lk_set[1].tag == lk_tag);
  assign lk_way  = !lk_hit0;

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      btb_vld_o    <= 1'b0;
      btb_target_o <= '0;
      btype_o      <= '0;
      bm_pred_o    <= '0;
      btb_way_o    <= 1'b0;
      ready_o      <= 1'b0;
    end else begin
      ready_o <= (state_q == ST_IDLE);
      if (lookup_valid_i && state_q == ST_IDLE && (lk_hit0 || lk_hit1)) begin
        btb_vld_o    <= 1'b1;
        btb_target_o <= lk_set[lk_way].target;
        btype_o      <= lk_set[lk_way].btype;
        bm_pred_o    <= lk_set[lk_way].ctr;
        btb_way_o    <= lk_way;
      end else begin
        btb_vld_o    <= 1'b0;
        btb_target_o <= '0;
        btype_o      <= '0;
        bm_pred_o    <= '0;
        btb_way_o    <= 1'b0;
      end
    end
  end

  // T0: forward the pending T1 write so back-to-back updates chain.
  always_comb begin
    fset = tr_set;
    flru = tr_lru;
    if (t1_we && t1_idx == c1_btb_vpc_i[IDX-1:0]) begin
      for (int w = 0; w < 2; w++)
        if (t1_mask[w]) fset[w] = t1_entry;
      if (t1_lru_we) flru = t1_lru;
    end
  end

  logic [29:0] tr_tag;
  logic        hit0, hit1, hit, hway;
  assign tr_tag = c1_btb_vpc_i >> IDX;
  assign hit0   = fset[0].valid && (fset[0].tag == tr_tag);
  assign hit1   = fset[1].valid && (fset[1].tag == tr_tag);
  assign hit    = hit0 || hit1;
  assign hway   = !hit0;

  always_comb begin
    d_we     = 1'b0;
    d_mask   = hway ? 2'b10 : 2'b01;
    d_entry  = fset[hway];
    d_lru_we = 1'b0;
    d_lru    = !hway;
    if (rcu_excp_i) begin
      if (c1_bnch_present_i && hit) begin
        d_we           = 1'b1;
        d_lru_we       = 1'b1;
        d_entry.target = c1_btb_target_i[31:2];
        d_entry.btype  = c1_bnch_type_i;
        if (c1_bnch_type_i == BT_COND) d_entry.ctr = sat_inc(fset[hway].ctr);
      end else if (c1_bnch_present_i) begin
        d_we     = 1'b1;
        d_lru_we = 1'b1;
        d_mask   = flru ? 2'b10 : 2'b01;
        d_lru    = !flru;
        d_entry  = '{valid: 1'b1, tag: tr_tag, target: c1_btb_target_i[31:2],
                     btype: c1_bnch_type_i, ctr: CTR_INIT};
      end else if (hit) begin
        d_we        = 1'b1;
        d_entry.ctr = sat_dec(fset[hway].ctr);
      end
    end else if (c1_btb_bm_mod_i && hit) begin
      d_we        = 1'b1;
      d_lru_we    = 1'b1;
      d_entry.ctr = c1_bnch_tkn_i ? sat_inc(fset[hway].ctr) : sat_dec(fset[hway].ctr);
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i || state_q != ST_IDLE) begin
      t1_we     <= 1'b0;
      t1_lru_we <= 1'b0;
      t1_lru    <= 1'b0;
      t1_idx    <= '0;
      t1_mask   <= '0;
      t1_entry  <= '0;
    end else begin
      t1_we     <= d_we;
      t1_lru_we <= d_lru_we;
      t1_lru    <= d_lru;
      t1_idx    <= c1_btb_vpc_i[IDX-1:0];
      t1_mask   <= d_mask;
      t1_entry  <= d_entry;
    end
  end

  // Single write port shared by the init sweep and T1.
  assign we       = !cpu_reset_i && (sweep || t1_we);
  assign wr_idx   = sweep ? idx_q : t1_idx;
  assign wr_mask  = sweep ? 2'b11 : t1_mask;
  assign wr_entry = sweep ? '0 : t1_entry;
  assign lru_we   = sweep || t1_lru_we;
  assign wr_lru   = sweep ? 1'b0 : t1_lru;

endmodule

// File: tb/tb_btb_update_engine.sv
// Randomized bench for btb_update_engine against an array-based model of
// the BTB contents, plus directed reset/allocate/saturate/replace cases.
module tb_btb_update_engine;

  logic        cpu_clock_i = 1'b0;
  logic        cpu_reset_i = 1'b1;
  logic        lookup_valid_i = 1'b0;
  logic [29:0] lookup_pc_i = '0;
  logic        btb_vld_o, btb_way_o, ready_o;
  logic [29:0] btb_target_o;
  logic [1:0]  btype_o, bm_pred_o;
  logic [29:0] c1_btb_vpc_i = '0;
  logic [31:0] c1_btb_target_i = '0;
  logic [1:0]  c1_cntr_pred_i = '0;
  logic        c1_bnch_tkn_i = 1'b0;
  logic        c1_bnch_present_i = 1'b0;
  logic [1:0]  c1_bnch_type_i = '0;
  logic        c1_btb_way_i = 1'b0;
  logic        c1_btb_bm_mod_i = 1'b0;
  logic        rcu_excp_i = 1'b0;

  btb_update_engine #(.SETS(64)) dut (
    .cpu_clock_i(cpu_clock_i), .cpu_reset_i(cpu_reset_i),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .btb_vld_o(btb_vld_o), .btb_target_o(btb_target_o), .btype_o(btype_o),
    .bm_pred_o(bm_pred_o), .btb_way_o(btb_way_o), .ready_o(ready_o),
    .c1_btb_vpc_i(c1_btb_vpc_i), .c1_btb_target_i(c1_btb_target_i),
    .c1_cntr_pred_i(c1_cntr_pred_i), .c1_bnch_tkn_i(c1_bnch_tkn_i),
    .c1_bnch_present_i(c1_bnch_present_i), .c1_bnch_type_i(c1_bnch_type_i),
    .c1_btb_way_i(c1_btb_way_i), .c1_btb_bm_mod_i(c1_btb_bm_mod_i),
    .rcu_excp_i(rcu_excp_i)
  );

  always #5 cpu_clock_i = ~cpu_clock_i;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Model: what each set/way holds, and which way is the next victim.
  bit m_vld [64][2];
  int m_tag [64][2];
  int m_tgt [64][2];
  int m_typ [64][2];
  int m_ctr [64][2];
  int m_lru [64];

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_vld[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0;
        m_typ[s][w] = 0; m_ctr[s][w] = 0;
      end
    end
  endfunction

  function automatic int find(input int s, input int tag);
    if (m_vld[s][0] && m_tag[s][0] == tag) return 0;
    if (m_vld[s][1] && m_tag[s][1] == tag) return 1;
    return -1;
  endfunction

  function automatic void model_train(input int vpc, input int tgt, input int typ,
                                      input bit tkn, input bit pres, input bit bm, input bit ex);
    int s, tag, w, v;
    s = vpc % 64; tag = vpc / 64; w = find(s, tag);
    if (ex) begin
      if (pres && w >= 0) begin
        m_tgt[s][w] = tgt; m_typ[s][w] = typ;
        if (typ == 0 && m_ctr[s][w] < 3) m_ctr[s][w]++;
        m_lru[s] = 1 - w;
      end else if (pres) begin
        v = m_lru[s];
        m_vld[s][v] = 1; m_tag[s][v] = tag; m_tgt[s][v] = tgt;
        m_typ[s][v] = typ; m_ctr[s][v] = 2;
        m_lru[s] = 1 - v;
      end else if (w >= 0 && m_ctr[s][w] > 0) m_ctr[s][w]--;
    end else if (bm && w >= 0) begin
      if (tkn && m_ctr[s][w] < 3) m_ctr[s][w]++;
      else if (!tkn && m_ctr[s][w] > 0) m_ctr[s][w]--;
      m_lru[s] = 1 - w;
    end
  endfunction

  task automatic train(input int vpc, input logic [31:0] tgt, input int typ,
                       input bit tkn, input bit pres, input bit bm, input bit ex);
    c1_btb_vpc_i = 30'(vpc); c1_btb_target_i = tgt; c1_bnch_type_i = 2'(typ);
    c1_bnch_tkn_i = tkn; c1_bnch_present_i = pres; c1_btb_bm_mod_i = bm; rcu_excp_i = ex;
    c1_btb_way_i = 1'($urandom); c1_cntr_pred_i = 2'($urandom);
    model_train(vpc, int'(tgt[31:2]), typ, tkn, pres, bm, ex);
    @(posedge cpu_clock_i); #1;
    c1_btb_bm_mod_i = 1'b0; rcu_excp_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge cpu_clock_i);
    #1;
  endtask

  task automatic lookup(input int pc, input string tag);
    int s, w;
    logic [35:0] exp;
    s = pc % 64; w = find(s, pc / 64);
    exp = '0;
    if (w >= 0) exp = {1'b1, 30'(m_tgt[s][w]), 2'(m_typ[s][w]), 2'(m_ctr[s][w]), 1'(w)};
    lookup_valid_i = 1'b1; lookup_pc_i = 30'(pc);
    @(posedge cpu_clock_i); #1;
    lookup_valid_i = 1'b0;
    chk(tag, {btb_vld_o, btb_target_o, btype_o, bm_pred_o, btb_way_o}, exp);
  endtask

  task automatic do_reset();
    cpu_reset_i = 1'b1; lookup_valid_i = 1'b0;
    c1_btb_bm_mod_i = 1'b0; rcu_excp_i = 1'b0;
    idle(2);
    chk("rst_out", {btb_vld_o, btb_target_o, btype_o, bm_pred_o, btb_way_o, ready_o}, '0);
    cpu_reset_i = 1'b0;
    model_reset();
    lookup_valid_i = 1'b1; lookup_pc_i = 30'h10;
    for (int i = 1; i <= 64; i++) begin
      @(posedge cpu_clock_i); #1;
      chk("init_ready", ready_o, 1'b0);
      chk("init_vld", btb_vld_o, 1'b0);
    end
    lookup_valid_i = 1'b0;
    idle(1);
    chk("ready_rise", ready_o, 1'b1);
  endtask

  initial begin
    int nt, nl, kind, pc;
    do_reset();

    // Allocate then lookup
    train(32'h100, 32'h2000, 0, 1, 1, 0, 1);
    idle(1);
    lookup(32'h100, "alloc_lk");
    chk("alloc_fields", {btb_vld_o, btb_target_o, bm_pred_o, btb_way_o}, {1'b1, 30'h800, 2'b10, 1'b0});
    idle(1);
    chk("idle_vld", btb_vld_o, 1'b0);

    // Saturation both ways
    repeat (4) train(32'h100, 32'h2000, 0, 1, 0, 1, 0);
    idle(1);
    lookup(32'h100, "sat_up_lk");
    chk("sat_up_ctr", bm_pred_o, 2'b11);
    repeat (5) train(32'h100, 32'h2000, 0, 0, 0, 1, 0);
    idle(1);
    lookup(32'h100, "sat_dn_lk");
    chk("sat_dn_ctr", bm_pred_o, 2'b00);

    // Replacement in set 0
    train(32'h140, 32'h3000, 1, 1, 1, 0, 1);
    train(32'h180, 32'h4000, 2, 1, 1, 0, 1);
    idle(1);
    lookup(32'h100, "repl_evict");
    chk("repl_evict_vld", btb_vld_o, 1'b0);
    lookup(32'h140, "repl_140");
    chk("repl_140_way", {btb_vld_o, btb_way_o}, 2'b11);
    lookup(32'h180, "repl_180");
    chk("repl_180_way", {btb_vld_o, btb_way_o}, 2'b10);

    // Back-to-back allocate + train
    train(32'h200, 32'h5000, 0, 1, 1, 0, 1);
    train(32'h200, 32'h5000, 0, 1, 0, 1, 0);
    idle(1);
    lookup(32'h200, "b2b_lk");
    chk("b2b_ctr", {btb_vld_o, bm_pred_o}, 3'b111);

    // Not-taken resolution on unseen branch
    train(32'h300, 32'h6000, 0, 0, 0, 0, 1);
    idle(1);
    lookup(32'h300, "nt_miss");
    chk("nt_miss_vld", btb_vld_o, 1'b0);

    // Random training bursts against the model
    for (int it = 0; it < 200; it++) begin
      nt = $urandom_range(1, 3);
      for (int k = 0; k < nt; k++) begin
        pc = ($urandom_range(0, 3) << 6) | $urandom_range(0, 2);
        kind = $urandom_range(0, 3);
        train(pc, $urandom, $urandom_range(0, 3), 1'($urandom),
              kind == 1, kind == 0 || kind == 3, kind == 1 || kind == 2);
      end
      idle(1);
      nl = $urandom_range(1, 2);
      for (int k = 0; k < nl; k++)
        lookup(($urandom_range(0, 3) << 6) | $urandom_range(0, 2), "rand_lk");
    end

    // Reset mid-run must wipe everything
    do_reset();
    lookup(32'h180, "post_rst_180");
    lookup(32'h200, "post_rst_200");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
